// File: rtl/pair_frame_receiver_pkg.sv
// Shared types for the operand-pair serial receiver: FSM states, pair struct, limits.
package pair_pkg;
  localparam int PAIR_W = 2;
  localparam int ERR_CNT_MAX = 255;

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, HOLD} state_t;

  typedef struct packed {
    logic [PAIR_W-1:0] a;
    logic [PAIR_W-1:0] b;
  } pair_t;
endpackage

// File: rtl/pair_frame_receiver_frame_shifter.sv
// Data path of the receiver: 2W-bit MSB-first shift register, bit counter and running parity.
module frame_shifter
  import pair_pkg::*;
#(
  parameter int W = PAIR_W
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic shift_en,
  input  logic bit_in,
  output logic done,
  output logic parity,
  output pair_t pair
);
  localparam int CW = (2 * W > 1) ? $clog2(2 * W) : 1;

  logic [2*W-1:0] shreg;
  logic [CW-1:0]  cnt;

  // clear only restarts counting; the register keeps the previous pair until overwritten
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg  <= '0;
      cnt    <= '0;
      parity <= 1'b0;
    end else if (clear) begin
      cnt    <= '0;
      parity <= 1'b0;
    end else if (shift_en) begin
      shreg  <= {shreg[2*W-2:0], bit_in};
      cnt    <= cnt + 1'b1;
      parity <= parity ^ bit_in;
    end
  end

  assign done = shift_en && (cnt == CW'(2 * W - 1));
  assign pair = shreg;
endmodule

// File: rtl/pair_frame_receiver.sv
// Framed serial-to-parallel operand-pair receiver with valid/ready output handshake.
// Optional parity check and error counter enabled by defining PAIR_PARITY_EN.
module pair_frame_receiver
  import pair_pkg::*;
#(
  parameter int W = PAIR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ser_in,
  input  logic         ser_valid,
  output logic         ser_ready,
  output logic [W-1:0] pair_a,
  output logic [W-1:0] pair_b,
  output logic         pair_valid,
  input  logic         pair_ready,
  output logic         par_err,
  output logic [7:0]   err_cnt
);
  state_t state;
  logic   accept;
  logic   clear;
  logic   shift_en;
  logic   done;
  logic   par_acc;
  pair_t  pair;

  assign accept   = ser_valid && ser_ready;
  assign clear    = (state == IDLE) && accept && ser_in;
  assign shift_en = (state == SHIFT) && accept;

  frame_shifter #(.W(W)) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .shift_en(shift_en),
    .bit_in  (ser_in),
    .done    (done),
    .parity  (par_acc),
    .pair    (pair)
  );

  assign pair_a = pair.a;
  assign pair_b = pair.b;

`ifdef PAIR_PARITY_EN
  logic       par_err_q;
  logic [7:0] err_cnt_q;
  assign par_err = par_err_q;
  assign err_cnt = err_cnt_q;
`else
  logic unused_par;
  assign unused_par = par_acc;
  assign par_err    = 1'b0;
  assign err_cnt    = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ser_ready  <= 1'b1;
      pair_valid <= 1'b0;
`ifdef PAIR_PARITY_EN
      par_err_q  <= 1'b0;
      err_cnt_q  <= '0;
`endif
    end else begin
`ifdef PAIR_PARITY_EN
      par_err_q <= 1'b0;
`endif
      case (state)
        IDLE: if (accept && ser_in) state <= SHIFT;
        SHIFT: begin
          if (done) begin
`ifdef PAIR_PARITY_EN
            state      <= PARITY;
`else
            state      <= HOLD;
            pair_valid <= 1'b1;
            ser_ready  <= 1'b0;
`endif
          end
        end
        PARITY: begin
`ifdef PAIR_PARITY_EN
          if (accept) begin
            if (ser_in == par_acc) begin
              state      <= HOLD;
              pair_valid <= 1'b1;
              ser_ready  <= 1'b0;
            end else begin
              state     <= IDLE;
              par_err_q <= 1'b1;
              if (err_cnt_q != 8'(ERR_CNT_MAX)) err_cnt_q <= err_cnt_q + 8'd1;
            end
          end
`else
          state <= IDLE;
`endif
        end
        HOLD: begin
          if (pair_ready) begin
            state      <= IDLE;
            pair_valid <= 1'b0;
            ser_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pair_frame_receiver.sv
// Self-checking bench for pair_frame_receiver (W=2); parity cases run when PAIR_PARITY_EN is defined.
module tb_pair_frame_receiver;
  logic       clk = 1'b0;
  logic       rst;
  logic       ser_in;
  logic       ser_valid;
  logic       ser_ready;
  logic [1:0] pair_a;
  logic [1:0] pair_b;
  logic       pair_valid;
  logic       pair_ready;
  logic       par_err;
  logic [7:0] err_cnt;

  int total = 0;
  int bad   = 0;
  int exp_err = 0;

  typedef struct packed {
    logic [1:0] a;
    logic [1:0] b;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [3:0] data;
    int         lead;
    bit         gaps;
    logic [1:0] ea;
    logic [1:0] eb;
  } vec_t;
  vec_t vecs[5];

  pair_frame_receiver dut (
    .clk       (clk),
    .rst       (rst),
    .ser_in    (ser_in),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready),
    .pair_a    (pair_a),
    .pair_b    (pair_b),
    .pair_valid(pair_valid),
    .pair_ready(pair_ready),
    .par_err   (par_err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scores a transfer if one happens at the coming edge, then advances one cycle.
  task automatic step();
    exp_t e;
    if (pair_valid && pair_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_transfer: got a=%0h b=%0h required no transfer", pair_a, pair_b);
      end else begin
        e = sb.pop_front();
        chk("pair_a", 32'(pair_a), 32'(e.a));
        chk("pair_b", 32'(pair_b), 32'(e.b));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [3:0] data, input int lead, input bit gaps,
                            input bit bad_par, input logic [1:0] ea, input logic [1:0] eb);
    bit   q[$];
    bit   ok;
    exp_t e;
    q.push_back(1'b1);
    for (int i = 3; i >= 0; i--) q.push_back(data[i]);
`ifdef PAIR_PARITY_EN
    q.push_back((^data) ^ bad_par);
    ok = !bad_par;
`else
    ok = 1'b1;
`endif
    if (ok) begin
      e.a = ea;
      e.b = eb;
      sb.push_back(e);
    end
    for (int i = 0; i < lead; i++) begin
      ser_valid = 1'b1;
      ser_in    = 1'b0;
      step();
      chk("idle_ready", 32'(ser_ready), 32'd1);
    end
    for (int i = 0; i < q.size(); i++) begin
      if (gaps && i > 0) begin
        ser_valid = 1'b0;
        ser_in    = 1'($urandom_range(0, 1));
        step();
        chk("gap_ready", 32'(ser_ready), 32'd1);
      end
      ser_valid = 1'b1;
      ser_in    = q[i];
      chk("ser_ready", 32'(ser_ready), 32'd1);
      step();
      if (i < q.size() - 1) chk("early_valid", 32'(pair_valid), 32'd0);
    end
    ser_valid = 1'b0;
    if (ok) begin
      chk("valid_latency", 32'(pair_valid), 32'd1);
      chk("hold_ser_ready", 32'(ser_ready), 32'd0);
      chk("no_par_err", 32'(par_err), 32'd0);
    end else begin
      if (exp_err < 255) exp_err++;
      chk("par_err_pulse", 32'(par_err), 32'd1);
      chk("err_cnt", 32'(err_cnt), 32'(exp_err));
      chk("bad_no_valid", 32'(pair_valid), 32'd0);
      step();
      chk("par_err_clear", 32'(par_err), 32'd0);
    end
  endtask

  initial begin
    vecs[0] = '{4'b1001, 0, 1'b0, 2'b10, 2'b01};
    vecs[1] = '{4'b1001, 2, 1'b1, 2'b10, 2'b01};
    vecs[2] = '{4'b0000, 1, 1'b0, 2'b00, 2'b00};
    vecs[3] = '{4'b1111, 0, 1'b1, 2'b11, 2'b11};
    vecs[4] = '{4'b0110, 0, 1'b0, 2'b01, 2'b10};

    rst        = 1'b1;
    ser_valid  = 1'b0;
    ser_in     = 1'b0;
    pair_ready = 1'b0;
    #1;
    chk("rst_ser_ready", 32'(ser_ready), 32'd1);
    chk("rst_pair_valid", 32'(pair_valid), 32'd0);
    chk("rst_pair_a", 32'(pair_a), 32'd0);
    chk("rst_pair_b", 32'(pair_b), 32'd0);
    chk("rst_par_err", 32'(par_err), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // pair_ready held high: transfer in the first HOLD cycle
    pair_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      send_frame(vecs[v].data, vecs[v].lead, vecs[v].gaps, 1'b0, vecs[v].ea, vecs[v].eb);
      step();
      chk("post_xfer_valid", 32'(pair_valid), 32'd0);
      chk("post_xfer_ready", 32'(ser_ready), 32'd1);
    end

    // backpressure: 10 HOLD cycles with upstream offering bits
    pair_ready = 1'b0;
    send_frame(4'b0111, 0, 1'b0, 1'b0, 2'b01, 2'b11);
    for (int i = 0; i < 10; i++) begin
      ser_valid = 1'b1;
      ser_in    = 1'($urandom_range(0, 1));
      step();
      chk("bp_ser_ready", 32'(ser_ready), 32'd0);
      chk("bp_valid", 32'(pair_valid), 32'd1);
      chk("bp_a_stable", 32'(pair_a), 32'd1);
      chk("bp_b_stable", 32'(pair_b), 32'd3);
    end
    ser_valid  = 1'b0;
    pair_ready = 1'b1;
    step();
    chk("bp_release_valid", 32'(pair_valid), 32'd0);
    chk("bp_release_ready", 32'(ser_ready), 32'd1);

`ifdef PAIR_PARITY_EN
    send_frame(4'b1001, 0, 1'b0, 1'b1, 2'b10, 2'b01);
    for (int i = 0; i < 300; i++) send_frame(4'($urandom_range(0, 15)), 0, 1'b0, 1'b1, 2'b00, 2'b00);
    chk("err_cnt_sat", 32'(err_cnt), 32'd255);
`endif

    // reset after the start bit and two data bits
    ser_valid = 1'b1;
    ser_in = 1'b1;
    step();
    ser_in = 1'b1;
    step();
    ser_in = 1'b0;
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_ser_ready", 32'(ser_ready), 32'd1);
    chk("mid_rst_pair_valid", 32'(pair_valid), 32'd0);
    chk("mid_rst_pair_a", 32'(pair_a), 32'd0);
    chk("mid_rst_pair_b", 32'(pair_b), 32'd0);
    chk("mid_rst_par_err", 32'(par_err), 32'd0);
    chk("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
    ser_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_err = 0;
    send_frame(4'b0111, 0, 1'b0, 1'b0, 2'b01, 2'b11);
    step();
    chk("fresh_post_valid", 32'(pair_valid), 32'd0);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pair_frame_receiver.md
# pair_frame_receiver

Serial-to-parallel receiver that assembles an operand pair (A, B) from a one-bit framed stream and presents it on a valid/ready parallel port. It is the receiving end for the operand-pair datapath: upstream logic serializes pairs onto a single wire, and this block rebuilds the pair struct for the bitwise-combine logic downstream. It also provides a ready-based backpressure handshake and an optional parity check.

## Interface
- W, 2, operand width in bits; each frame carries 2*W data bits
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- ser_in  input  1  serial data bit
- ser_valid  input  1  ser_in is sampled only when ser_valid && ser_ready
- ser_ready  output  1  receiver accepts a bit this cycle
- pair_a  output  W  assembled operand A
- pair_b  output  W  assembled operand B
- pair_valid  output  1  pair_a/pair_b are stable and valid
- pair_ready  input  1  downstream accepts the pair
- par_err  output  1  one-cycle pulse when a frame is dropped for bad parity
- err_cnt  output  8  count of dropped frames; saturates at 255

## Operation
- Frame format, in acceptance order: start bit (1); A MSB-first; B MSB-first; parity bit (only with the macro).
- States:
  - IDLE: an accepted 0 is line idle and is ignored. An accepted 1 goes to SHIFT with bit counter = 0.
  - SHIFT: each accepted bit shifts into a 2W-bit register and increments the counter. After bit 2W-1 is accepted, go to PARITY if enabled, otherwise HOLD.
  - PARITY: the accepted bit must equal the XOR of the 2W data bits (even parity). On a match go to HOLD. On a mismatch pulse par_err, increment err_cnt (saturating), discard the frame and go to IDLE.
  - HOLD: pair_valid = 1 and ser_ready = 0. On pair_valid && pair_ready go to IDLE.
- ser_ready = 1 in IDLE, SHIFT and PARITY, 0 in HOLD; it is registered, decoded from the state.
- Cycles with ser_valid = 0 are gaps. Gaps are allowed anywhere in a frame and do not advance state.
- pair_a and pair_b are driven from the shift register. They hold their value in HOLD and until the next frame starts overwriting them.

## Timing
- Reset values: ser_ready 1, pair_valid 0, pair_a 0, pair_b 0, par_err 0, err_cnt 0. State = IDLE.
- Latency with the start bit accepted in cycle 0 and continuous valid:
  - Without parity: last data bit accepted in cycle 2W; pair_valid rises in cycle 2W+1.
  - With parity: parity bit accepted in cycle 2W+1; pair_valid rises in cycle 2W+2.
- Handshake and backpressure:
  - The pair is transferred in the cycle where pair_valid && pair_ready.
  - pair_valid falls and ser_ready rises in the next cycle.
  - Minimum frame-to-frame spacing is one IDLE cycle after the transfer.
  - No bit is lost under backpressure: upstream holds ser_in while ser_ready = 0.
- pair_ready held high during HOLD transfers in the first HOLD cycle.
- par_err is high for exactly the cycle after the bad parity bit is accepted.
- Reset asserted mid-frame or in HOLD clears everything immediately. A partial frame is lost, and the upstream sender must restart from a start bit.

## Configuration
- PAIR_PARITY_EN defined:
  - PARITY state and parity bit exist.
  - par_err and err_cnt operate as described above.
- PAIR_PARITY_EN undefined:
  - Frame is start + 2W bits.
  - PARITY state is absent.
  - par_err is tied to 0 and err_cnt to 0.

## Structure
- Package pair_pkg contains:
  - state enum: IDLE, SHIFT, PARITY, HOLD.
  - pair_t struct: logic [W-1:0] a, b.
  - Default W constant.
  - ERR_CNT_MAX = 255.
- Sub-module frame_shifter holds:
  - the 2W-bit shift register;
  - the bit counter;
  - the running-XOR parity accumulator.
  - Its controls are clear, shift enable and done flag; it exposes the pair_t output.
- The top level holds the FSM, the handshake and the error counter.

## Test plan
- W=2, no parity, continuous valid, stream 1,1,0,0,1 -> pair_a=2'b10, pair_b=2'b01, pair_valid high at cycle 5.
- Leading idle 0,0 and then a frame with ser_valid gaps every other cycle -> same pair; pair_valid 1 cycle after the last data bit.
- pair_ready held low for 10 cycles in HOLD while ser_valid=1 -> ser_ready=0 and pair stable throughout. Then release ready -> transfer, and ser_ready returns 1 the next cycle.
- With PAIR_PARITY_EN:
  - stream 1,1,0,0,1,0 -> pair accepted;
  - stream 1,1,0,0,1,1 -> par_err one pulse, err_cnt=1, pair_valid stays 0;
  - 300 bad frames -> err_cnt=255.
- rst asserted after 2 data bits, then a fresh frame 1,0,1,1,1 -> pair_a=2'b01, pair_b=2'b11. All outputs return to reset values during rst.
